// File: rtl/output_arbiter_if.sv
// Router output-port bundle: upstream request/ready lanes, credit return and registered output.
// The arbiter takes the slave view; the upstream/downstream side takes the master view.
interface output_arbiter_if #(
  parameter int unsigned FLIT_W = 10,
  parameter int unsigned CW     = 6
);
  logic [4:0]          req_valid;
  logic [5*FLIT_W-1:0] req_flit;
  logic [4:0]          req_ready;
  logic                credit_in;
  logic                out_valid;
  logic [FLIT_W-1:0]   out_flit;
  logic [CW-1:0]       credits;
  logic [2:0]          owner;
  logic                protocol_err;

  modport master (
    output req_valid, req_flit, credit_in,
    input  req_ready, out_valid, out_flit, credits, owner, protocol_err
  );

  modport slave (
    input  req_valid, req_flit, credit_in,
    output req_ready, out_valid, out_flit, credits, owner, protocol_err
  );
endinterface

// File: rtl/output_arbiter.sv
// Wormhole output arbiter: round-robin over five inputs, lock until tail, one register stage,
// credit-based flow control toward a downstream VC buffer.
module output_arbiter #(
  parameter int unsigned FLIT_W  = 10,
  parameter int unsigned CREDITS = 32,
  parameter int unsigned CW      = 6
) (
  input logic             clk,
  input logic             reset,
  output_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e            r_state;
  logic [2:0]        r_owner;
  logic [2:0]        r_ptr;
  logic [CW-1:0]     r_credits;
  logic              r_out_valid;
  logic [FLIT_W-1:0] r_out_flit;
  logic              r_err;

  logic [FLIT_W-1:0] w_flit [5];
  logic [4:0]        w_ready;
  logic [2:0]        w_sel;
  logic              w_found;
  logic              w_stray;
  logic              w_has_cred;
  logic              w_xfer;
  logic [FLIT_W-1:0] w_xflit;

  assign w_has_cred = (r_credits != '0);

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_flit[i] = bus.req_flit[FLIT_W*i +: FLIT_W];
    end
  end

  always_comb begin
    w_ready = '0;
    w_sel   = '0;
    w_found = 1'b0;
    w_stray = 1'b0;
    // Body (00) and tail (10) both have the low type bit clear.
    for (int i = 0; i < 5; i++) begin
      if (bus.req_valid[i] && !w_flit[i][FLIT_W-2]) w_stray = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % 5;
      if (!w_found && bus.req_valid[idx] && w_flit[idx][FLIT_W-2]) begin
        w_found = 1'b1;
        w_sel   = 3'(idx);
      end
    end
    if (r_state == StIdle) begin
      if (w_found && w_has_cred) w_ready[w_sel] = 1'b1;
    end else begin
      w_sel = r_owner;
      if (bus.req_valid[r_owner] && w_has_cred) w_ready[r_owner] = 1'b1;
    end
  end

  assign w_xfer  = |w_ready;
  assign w_xflit = w_flit[w_sel];

  // Keep upstream from popping while reset holds the state.
  assign bus.req_ready    = w_ready & {5{reset}};
  assign bus.out_valid    = r_out_valid;
  assign bus.out_flit     = r_out_flit;
  assign bus.credits      = r_credits;
  assign bus.owner        = r_owner;
  assign bus.protocol_err = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_owner     <= 3'b111;
      r_ptr       <= 3'd0;
      r_credits   <= CW'(CREDITS);
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= w_xfer;
      if (w_xfer) r_out_flit <= w_xflit;

      if (w_xfer && !bus.credit_in) begin
        r_credits <= r_credits - CW'(1);
      end else if (!w_xfer && bus.credit_in) begin
        if (r_credits == CW'(CREDITS)) r_err <= 1'b1;
        else                           r_credits <= r_credits + CW'(1);
      end

      if (r_state == StIdle && w_stray) r_err <= 1'b1;

      unique case (r_state)
        StIdle: begin
          if (w_xfer) begin
            r_ptr <= (w_sel == 3'd4) ? 3'd0 : w_sel + 3'd1;
            if (!w_xflit[FLIT_W-1]) begin
              r_state <= StLocked;
              r_owner <= w_sel;
            end
          end
        end
        StLocked: begin
          if (w_xfer) begin
            if (w_xflit[FLIT_W-1:FLIT_W-2] == 2'b10) begin
              r_state <= StIdle;
              r_owner <= 3'b111;
            end else if (w_xflit[FLIT_W-2]) begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: cycle tables for wormhole and round-robin traffic,
// hand-written sequences for locking, credit exhaustion, errors and mid-packet reset.
module tb_output_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  output_arbiter_if #(.FLIT_W(10), .CW(6)) bus ();

  output_arbiter #(.FLIT_W(10), .CREDITS(32), .CW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  v;
    logic [49:0] f;
    logic        cin;
    logic [4:0]  er;
    logic        ov;
    logic [9:0]  of;
    logic [2:0]  ow;
    logic [5:0]  cr;
    logic        err;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [49:0] fl(input int idx, input logic [9:0] f);
    logic [49:0] r;
    r = '0;
    r[idx*10 +: 10] = f;
    return r;
  endfunction

  function automatic vec_t mk(input logic rst, input logic [4:0] v, input logic [49:0] f,
                              input logic cin, input logic [4:0] er, input logic ov,
                              input logic [9:0] of, input logic [2:0] ow, input logic [5:0] cr);
    vec_t t;
    t.rst = rst; t.v = v; t.f = f; t.cin = cin; t.er = er;
    t.ov = ov; t.of = of; t.ow = ow; t.cr = cr; t.err = 1'b0;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v, input logic [49:0] f, input logic cin);
    bus.req_valid = v;
    bus.req_flit  = f;
    bus.credit_in = cin;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(5'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic [49:0] rr_f;
  logic [49:0] s_pkt [4];

  initial begin
    checks = 0;
    errors = 0;

    // Reset held with random traffic.
    reset = 1'b0;
    bus.req_valid = 5'($urandom);
    bus.req_flit  = 50'({$urandom, $urandom});
    bus.credit_in = 1'($urandom);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", bus.req_ready, 5'b0);
    chk("rst_ov", bus.out_valid, 1'b0);
    chk("rst_cred", bus.credits, 6'd32);
    chk("rst_owner", bus.owner, 3'd7);
    chk("rst_err", bus.protocol_err, 1'b0);
    drive(5'b0, '0, 1'b0);
    reset = 1'b1;
    tick();
    chk("rel_ready", bus.req_ready, 5'b0);
    chk("rel_ov", bus.out_valid, 1'b0);
    chk("rel_of", bus.out_flit, 10'h0);
    chk("rel_cred", bus.credits, 6'd32);
    chk("rel_owner", bus.owner, 3'd7);

    // Wormhole on E, then round-robin N/S/L singles with credit return every cycle.
    rr_f = fl(0, 10'h301) | fl(1, 10'h302) | fl(4, 10'h304);
    tbl[0]  = mk(1, 5'b00100, fl(2, 10'h1A5), 0, 5'b00100, 1, 10'h1A5, 3'd2, 6'd31);
    tbl[1]  = mk(0, 5'b00100, fl(2, 10'h033), 0, 5'b00100, 1, 10'h033, 3'd2, 6'd30);
    tbl[2]  = mk(0, 5'b00100, fl(2, 10'h2FF), 0, 5'b00100, 1, 10'h2FF, 3'd7, 6'd29);
    tbl[3]  = mk(0, 5'b00000, '0,             0, 5'b00000, 0, 10'h000, 3'd7, 6'd29);
    tbl[4]  = mk(1, 5'b10011, rr_f,           1, 5'b00001, 1, 10'h301, 3'd7, 6'd32);
    tbl[5]  = mk(0, 5'b10011, rr_f,           1, 5'b00010, 1, 10'h302, 3'd7, 6'd32);
    tbl[6]  = mk(0, 5'b10011, rr_f,           1, 5'b10000, 1, 10'h304, 3'd7, 6'd32);
    tbl[7]  = mk(0, 5'b10011, rr_f,           1, 5'b00001, 1, 10'h301, 3'd7, 6'd32);
    tbl[8]  = mk(0, 5'b10011, rr_f,           1, 5'b00010, 1, 10'h302, 3'd7, 6'd32);
    tbl[9]  = mk(0, 5'b10011, rr_f,           1, 5'b10000, 1, 10'h304, 3'd7, 6'd32);
    tbl[10] = mk(0, 5'b00000, '0,             0, 5'b00000, 0, 10'h000, 3'd7, 6'd32);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].v, tbl[i].f, tbl[i].cin);
      chk($sformatf("tbl%0d_ready", i), bus.req_ready, tbl[i].er);
      tick();
      chk($sformatf("tbl%0d_ov", i), bus.out_valid, tbl[i].ov);
      if (tbl[i].ov) chk($sformatf("tbl%0d_of", i), bus.out_flit, tbl[i].of);
      chk($sformatf("tbl%0d_owner", i), bus.owner, tbl[i].ow);
      chk($sformatf("tbl%0d_cred", i), bus.credits, tbl[i].cr);
      chk($sformatf("tbl%0d_err", i), bus.protocol_err, tbl[i].err);
    end

    // S holds a 4-flit packet; W raises a head from the second flit on.
    do_reset();
    s_pkt[0] = fl(1, 10'h111);
    s_pkt[1] = fl(1, 10'h022);
    s_pkt[2] = fl(1, 10'h033);
    s_pkt[3] = fl(1, 10'h244);
    drive(5'b00010, s_pkt[0], 0);
    chk("lock0_ready", bus.req_ready, 5'b00010);
    tick();
    chk("lock0_of", bus.out_flit, 10'h111);
    chk("lock0_owner", bus.owner, 3'd1);
    for (int i = 1; i < 4; i++) begin
      drive(5'b01010, s_pkt[i] | fl(3, 10'h155), 0);
      chk($sformatf("lock%0d_ready", i), bus.req_ready, 5'b00010);
      tick();
      chk($sformatf("lock%0d_of", i), bus.out_flit, s_pkt[i][19:10]);
      chk($sformatf("lock%0d_owner", i), bus.owner, (i == 3) ? 3'd7 : 3'd1);
    end
    drive(5'b01000, fl(3, 10'h155), 0);
    chk("lockw_ready", bus.req_ready, 5'b01000);
    tick();
    chk("lockw_of", bus.out_flit, 10'h155);
    chk("lockw_owner", bus.owner, 3'd3);
    drive(5'b01000, fl(3, 10'h266), 0);
    tick();
    chk("lockw_tail_owner", bus.owner, 3'd7);
    chk("lock_cred", bus.credits, 6'd26);
    chk("lock_err", bus.protocol_err, 1'b0);

    // Credit exhaustion from N.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(5'b00001, fl(0, 10'h300 | 10'(i)), 0);
      chk($sformatf("ex%0d_ready", i), bus.req_ready, 5'b00001);
      tick();
      chk($sformatf("ex%0d_of", i), bus.out_flit, 10'h300 | 10'(i));
    end
    chk("ex_cred0", bus.credits, 6'd0);
    drive(5'b00001, fl(0, 10'h3AA), 0);
    chk("ex_blk_ready", bus.req_ready, 5'b0);
    tick();
    chk("ex_blk_ov", bus.out_valid, 1'b0);
    drive(5'b00001, fl(0, 10'h3AA), 1);
    chk("ex_cin_ready", bus.req_ready, 5'b0);
    tick();
    chk("ex_cin_cred", bus.credits, 6'd1);
    drive(5'b00001, fl(0, 10'h3AB), 0);
    chk("ex_one_ready", bus.req_ready, 5'b00001);
    tick();
    chk("ex_one_ov", bus.out_valid, 1'b1);
    chk("ex_one_cred", bus.credits, 6'd0);
    drive(5'b00001, fl(0, 10'h3AC), 0);
    chk("ex_again_ready", bus.req_ready, 5'b0);
    tick();
    chk("ex_again_ov", bus.out_valid, 1'b0);
    drive(5'b00001, fl(0, 10'h3AC), 1);
    tick();
    drive(5'b00001, fl(0, 10'h3AD), 1);
    chk("ex_both_ready", bus.req_ready, 5'b00001);
    tick();
    chk("ex_both_ov", bus.out_valid, 1'b1);
    chk("ex_both_cred", bus.credits, 6'd1);
    chk("ex_err", bus.protocol_err, 1'b0);

    // Stray body while idle, then reset mid-packet.
    do_reset();
    drive(5'b10000, fl(4, 10'h0AA), 0);
    chk("err_ready", bus.req_ready, 5'b0);
    tick();
    chk("err_ov", bus.out_valid, 1'b0);
    chk("err_flag", bus.protocol_err, 1'b1);
    drive(5'b00001, fl(0, 10'h101), 0);
    tick();
    chk("mid_owner", bus.owner, 3'd0);
    drive(5'b00001, fl(0, 10'h002), 0);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_owner", bus.owner, 3'd7);
    chk("arst_err", bus.protocol_err, 1'b0);
    chk("arst_cred", bus.credits, 6'd32);
    chk("arst_ov", bus.out_valid, 1'b0);
    tick();
    drive(5'b0, '0, 1'b1);
    reset = 1'b1;
    tick();
    chk("sat_cred", bus.credits, 6'd32);
    chk("sat_err", bus.protocol_err, 1'b1);
    drive(5'b0, '0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- Output-port stage sitting directly downstream of the five per-direction input modules (N, S, E, W, L) of a router.
- Arbitrates round-robin among head flits presented by the input modules, then locks the output to the winner (wormhole) until its tail flit passes.
- Forwards flits through one register stage.
- Enforces credit-based flow control against the downstream 32-slot VC buffer.

Parameters:
- FLIT_W, 10, flit width. Bits [9:8] are the type: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head+tail). Bits [7:0] are the payload.
- CREDITS, 32, initial and maximum credit count; equals the downstream buffer depth.
- CW, 6, credit counter width; must hold CREDITS.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  5  flit-present flags per input. Bit 0=N, 1=S, 2=E, 3=W, 4=L.
- req_flit  in  5*FLIT_W  packed flits; input i occupies [FLIT_W*i+FLIT_W-1 : FLIT_W*i].
- req_ready  out  5  one-hot or zero; the input module pops its flit when its bit and req_valid are both high.
- credit_in  in  1  one-cycle pulse; downstream freed one slot.
- out_valid  out  1  registered flit-valid to the downstream buffer write_en.
- out_flit  out  FLIT_W  registered flit.
- credits  out  CW  current credit count.
- owner  out  3  locked input index; 3'b111 when idle.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, owner=3'b111, rr pointer=0
  - credits=CREDITS
  - out_valid=0, out_flit=0, protocol_err=0
- Transfer: occurs in a cycle where req_valid[i] and req_ready[i] are both high. The flit appears on out_flit with out_valid=1 exactly one cycle later (latency 1).
  - out_valid=0 in any cycle following a cycle with no transfer.
  - req_ready is combinational from state, pointer, credits and req_valid/req_flit; it never depends on out_* signals.
- State IDLE:
  - An input is eligible if req_valid[i]=1 and its flit type is head or single.
  - If credits>0, grant the first eligible input searching pointer, pointer+1, ... mod 5, and assert req_ready for it that same cycle.
  - On grant, the pointer becomes (granted+1) mod 5.
  - Granted head: go to LOCKED with owner=granted.
  - Granted single: remain IDLE.
  - If credits==0: no grant; pointer and state are unchanged.
  - A valid body or tail flit seen at any input while IDLE is not granted and sets protocol_err.
- State LOCKED:
  - req_ready[owner]=req_valid[owner] && credits>0. All other ready bits are 0.
  - Transferring a tail returns the block to IDLE with owner=3'b111.
  - Transferring a body stays in LOCKED.
  - A head or single from the owner while LOCKED is still transferred and sets protocol_err; the lock is kept.
- Credits:
  - Decrement by 1 per transfer; increment by 1 per credit_in pulse.
  - Transfer and credit_in in the same cycle: count unchanged.
  - credit_in while credits==CREDITS and no transfer: count stays at CREDITS (saturate) and protocol_err sets.
  - Credits never go below 0, because transfers are blocked at 0.
- Reset mid-packet drops the lock immediately and discards any registered flit. Upstream must be reset in the same domain.
- protocol_err clears only on reset.

Test Plan:
1. Reset: hold reset=0 with random inputs -> out_valid=0, credits=32, owner=7, req_ready=0. Release with req_valid=0 -> outputs unchanged.
2. Single wormhole packet on E: head 0x1A5, body 0x033, tail 0x2FF, req_valid[2] held -> req_ready[2] high 3 cycles. out_flit = 0x1A5, 0x033, 0x2FF on cycles +1..+3. owner=2 during the packet, then 7. credits=29.
3. Round-robin: N, S and L each present single flits 0x3xx continuously with credit_in pulsed each cycle -> grants in order N, S, L, N, S, L. No starvation. credits stays 32 after the first return.
4. Lock: S holds a 4-flit packet while W raises a head mid-packet -> W not granted until the cycle after the S tail transfers. No interleaving appears on out_flit.
5. Credit exhaustion: 32 singles from N with no credit_in -> 32 transfers, credits=0, req_ready=0 thereafter. A single credit_in pulse -> exactly one more transfer. Simultaneous transfer + credit_in leaves credits unchanged.
6. Errors and reset: a body flit 0x0AA at L while IDLE -> no grant, protocol_err=1. Assert reset mid-packet -> owner=7, protocol_err=0, credits=32 asynchronously.
